// File: rtl/hex_scan_sched.sv
// Time-multiplexes one external hex-to-7-segment decoder across NUM_DIGITS displays,
// with round-robin arbitration of two digit writers. Optional blinking: HEX_SCAN_BLINK_EN.
module hex_scan_sched #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000
`ifdef HEX_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 25
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic [2:0]              idx0,
    input  logic [3:0]              val0,
    input  logic                    req1,
    input  logic [2:0]              idx1,
    input  logic [3:0]              val1,
    output logic [1:0]              grant,
    output logic [3:0]              dec_in,
    input  logic [6:0]              dec_seg,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    frame_done
`ifdef HEX_SCAN_BLINK_EN
    ,
    input  logic [NUM_DIGITS-1:0]   blink_mask
`endif
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0]    NUM_DIG4 = 4'(NUM_DIGITS);

    typedef enum logic [1:0] {LOAD, CAPT, WAIT} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   scan_idx_reg, scan_idx_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            ptr_reg;
    logic            wr_en;
    logic [2:0]      wr_idx;
    logic [3:0]      wr_val;
    logic [6:0]      cap_seg;
    logic [3:0]      digit_vals [NUM_DIGITS];

    // ptr_reg names the requester that wins the next tie
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (req0 && req1)
                grant = ptr_reg ? 2'b10 : 2'b01;
            else if (req0)
                grant = 2'b01;
            else if (req1)
                grant = 2'b10;
        end
    end

    assign wr_idx = grant[1] ? idx1 : idx0;
    assign wr_val = grant[1] ? val1 : val0;
    assign wr_en  = (grant != 2'b00) && ({1'b0, wr_idx} < NUM_DIG4);

    always_ff @(posedge clk) begin
        if (reset)
            ptr_reg <= 1'b0;
        else if (req0 && req1)
            ptr_reg <= grant[0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] digit_reg;
            logic [6:0] seg_reg;

            always_ff @(posedge clk) begin
                if (reset)
                    digit_reg <= 4'h0;
                else if (wr_en && wr_idx == 3'(gi))
                    digit_reg <= wr_val;
            end

            always_ff @(posedge clk) begin
                if (reset)
                    seg_reg <= 7'h7F;
                else if (state_reg == CAPT && scan_idx_reg == IW'(gi))
                    seg_reg <= cap_seg;
            end

            assign digit_vals[gi]       = digit_reg;
            assign hex_out[7*gi +: 7]   = seg_reg;
        end
    endgenerate

`ifdef HEX_SCAN_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] bcnt_reg;
    logic          phase_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt_reg  <= '0;
            phase_reg <= 1'b0;
        end else if (frame_done) begin
            if (bcnt_reg == BLINK_LAST) begin
                bcnt_reg  <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                bcnt_reg  <= bcnt_reg + 1'b1;
            end
        end
    end

    assign cap_seg = (blink_mask[scan_idx_reg] && phase_reg) ? 7'h7F : dec_seg;
`else
    assign cap_seg = dec_seg;
`endif

    always_comb begin
        state_next    = state_reg;
        scan_idx_next = scan_idx_reg;
        cnt_next      = cnt_reg;
        frame_done    = 1'b0;
        case (state_reg)
            LOAD: state_next = CAPT;
            CAPT: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next    = LOAD;
                    scan_idx_next = (scan_idx_reg == IDX_LAST) ? '0 : scan_idx_reg + 1'b1;
                    frame_done    = (scan_idx_reg == IDX_LAST);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= LOAD;
            scan_idx_reg <= '0;
            cnt_reg      <= '0;
            dec_in       <= 4'h0;
        end else begin
            state_reg    <= state_next;
            scan_idx_reg <= scan_idx_next;
            cnt_reg      <= cnt_next;
            if (state_reg == LOAD)
                dec_in <= digit_vals[scan_idx_reg];
        end
    end

endmodule
